// File: rtl/hs32_intctl_pkg.sv
// hs32_intctl_pkg: shared register map indices and FSM encodings for the interrupt controller
package hs32_intctl_pkg;
  localparam logic [4:0] REG_EN = 5'd24;
  localparam logic [4:0] REG_NMI = 5'd25;
  localparam logic [4:0] REG_PEND = 5'd26;
  localparam logic [4:0] REG_STAT = 5'd27;
  typedef enum logic {IDLE, REQ} state_t;
endpackage

// File: rtl/hs32_intctl_if.sv
// hs32_intctl_if: single-cycle memory-mapped slave port of the interrupt controller
interface hs32_intctl_if;
  logic [6:0] s_addr;
  logic s_rw;
  logic [31:0] s_din;
  logic [31:0] s_dout;
  logic s_valid;
  logic s_ready;
  modport master(output s_addr, s_rw, s_din, s_valid, input s_dout, s_ready);
  modport slave(input s_addr, s_rw, s_din, s_valid, output s_dout, s_ready);
endinterface

// File: rtl/hs32_prio24.sv
// hs32_prio24: fixed-priority encoder, lowest set index wins
module hs32_prio24 (
  input logic [23:0] req,
  output logic any,
  output logic [4:0] idx
);
  always_comb begin
    idx = 5'd0;
    for (int i = 23; i >= 0; i--) if (req[i]) idx = 5'(i);
  end
  assign any = |req;
endmodule

// File: rtl/hs32_intctl.sv
// hs32_intctl: vectored interrupt controller with edge-latched pending bits, masks and ISR table
module hs32_intctl
  import hs32_intctl_pkg::*;
#(
  parameter int NLINES = 24,
  parameter logic [NLINES-1:0] RESET_EN = '0
) (
  input logic i_clk,
  input logic reset,
  input logic [NLINES-1:0] interrupts,
  input logic iack,
  output logic intrq,
  output logic [4:0] vec,
  output logic [31:0] handler,
  output logic nmi,
  hs32_intctl_if.slave bus
);
  state_t state, state_nx;
  logic [NLINES-1:0] prev, pend, en, nmi_mask, set, clr, elig;
  logic [31:0] tbl [NLINES];
  logic [31:0] rdata;
  logic [4:0] widx, nmi_idx, all_idx, sel;
  logic wr, nmi_any, all_any, load;
  assign widx = bus.s_addr[6:2];
  assign wr = bus.s_valid && bus.s_rw;
  assign set = interrupts & ~prev;
  // new edges are OR-ed in after the clear so a same-cycle edge re-pends the line
  assign clr = (state == REQ && iack ? NLINES'(1) << vec : '0)
             | (wr && widx == REG_PEND ? bus.s_din[NLINES-1:0] : '0);
  assign elig = pend & (en | nmi_mask);
  assign intrq = state == REQ;
  assign sel = nmi_any ? nmi_idx : all_idx;
  hs32_prio24 u_prio_nmi (.req(24'(elig & nmi_mask)), .any(nmi_any), .idx(nmi_idx));
  hs32_prio24 u_prio_all (.req(24'(elig)), .any(all_any), .idx(all_idx));
  always_comb begin
    state_nx = state;
    load = 1'b0;
    if (state == IDLE && all_any) begin
      state_nx = REQ;
      load = 1'b1;
    end else if (state == REQ && iack) state_nx = IDLE;
  end
  always_comb begin
    rdata = '0;
    if (widx < 5'(NLINES)) rdata = tbl[widx];
    else if (widx == REG_EN) rdata = 32'(en);
    else if (widx == REG_NMI) rdata = 32'(nmi_mask);
    else if (widx == REG_PEND) rdata = 32'(pend);
    else if (widx == REG_STAT) rdata = {26'b0, state == REQ, vec};
  end
  always_ff @(posedge i_clk) begin
    if (!reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge i_clk) begin
    if (!reset) begin
      prev <= '0;
      pend <= '0;
      en <= RESET_EN;
      nmi_mask <= '0;
      vec <= '0;
      handler <= '0;
      nmi <= 1'b0;
      bus.s_ready <= 1'b0;
      bus.s_dout <= '0;
      for (int i = 0; i < NLINES; i++) tbl[i] <= '0;
    end else begin
      prev <= interrupts;
      pend <= (pend & ~clr) | set;
      bus.s_ready <= bus.s_valid;
      bus.s_dout <= bus.s_valid && !bus.s_rw ? rdata : '0;
      // request outputs freeze once latched; later table or mask writes do not disturb them
      if (load) begin
        vec <= sel;
        handler <= tbl[sel];
        nmi <= nmi_mask[sel];
      end
      if (wr && widx < 5'(NLINES)) tbl[widx] <= bus.s_din;
      if (wr && widx == REG_EN) en <= bus.s_din[NLINES-1:0];
      if (wr && widx == REG_NMI) nmi_mask <= bus.s_din[NLINES-1:0];
    end
  end
endmodule
